// File: rtl/load_reg_arbiter_if.sv
// Bundle between the requesters and the shared load/hold register controller.
// The controller takes the slave modport; the producer side takes master.
interface load_reg_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] data;
    logic [N-1:0]       gnt;
    logic               sel;
    logic [WIDTH-1:0]   q;
    logic [IDX_W-1:0]   owner;
    logic               busy;

    modport master (output req, data, input gnt, sel, q, owner, busy);
    modport slave  (input req, data, output gnt, sel, q, owner, busy);
endinterface

// File: rtl/load_reg_arbiter.sv
// Round-robin arbiter owning a shared load-enabled register, with a hold window after each load.
// Define LOAD_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (pointer pinned at 0).
module load_reg_arbiter #(
    parameter int N           = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    load_reg_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N);
    localparam logic [3:0]       HOLD_INIT = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

    state_t           r_state, w_state_next;
    logic [IDX_W-1:0] r_ptr, r_winner, r_owner, w_winner;
    logic [N-1:0]     r_gnt;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             w_found, w_sel, w_busy;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    // First set request at or after the pointer, wrapping modulo N.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && bus.req[wrap_add(r_ptr, k)]) begin
                w_winner = wrap_add(r_ptr, k);
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_sel        = 1'b1;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) w_state_next = S_GRANT;
            end
            S_GRANT: begin
                w_sel        = 1'b0;
                w_busy       = 1'b1;
                w_state_next = (HOLD_CYCLES > 0) ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                w_busy = 1'b1;
                if (r_cnt == 4'd0) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The winner is latched on entry to GRANT so a dropped request still completes its load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt    <= '0;
            r_winner <= '0;
            r_ptr    <= '0;
            r_cnt    <= 4'd0;
            r_q      <= '0;
            r_owner  <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt[w_winner] <= 1'b1;
                        r_winner        <= w_winner;
                    end
                end
                S_GRANT: begin
                    r_q     <= bus.data[r_winner*WIDTH +: WIDTH];
                    r_owner <= r_winner;
                    r_cnt   <= HOLD_INIT;
`ifdef LOAD_ARB_FIXED_PRIO_EN
                    r_ptr   <= '0;
`else
                    r_ptr   <= (r_winner == LAST_IDX) ? '0 : r_winner + 1'b1;
`endif
                end
                S_HOLD: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.sel   = w_sel;
    assign bus.busy  = w_busy;
    assign bus.q     = r_q;
    assign bus.owner = r_owner;
endmodule

// File: tb/tb_load_reg_arbiter.sv
// Scoreboard bench for load_reg_arbiter: stimulus queues expected loads, a monitor checks each grant.
// Expected winners follow round-robin unless LOAD_ARB_FIXED_PRIO_EN is defined.
module tb_load_reg_arbiter;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_reg_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    load_reg_arbiter #(.N(N), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N-1:0]     gnt;
        logic [WIDTH-1:0] q;
        logic [1:0]       owner;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    function automatic logic [31:0] status();
        return 32'({bus.q, bus.sel, bus.gnt, bus.busy, bus.owner});
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] q, input logic sel, input logic [3:0] gnt,
                                       input logic busy, input logic [1:0] owner);
        return 32'({q, sel, gnt, busy, owner});
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic expect_load(input int idx, input logic [7:0] v);
        exp_t e;
        e.gnt      = '0;
        e.gnt[idx] = 1'b1;
        e.q        = v;
        e.owner    = 2'(idx);
        exp_q.push_back(e);
    endtask

    // Monitor: a GRANT cycle pops the next expectation; q/owner are checked one edge later.
    initial begin
        exp_t pend;
        bit   have_pend;
        have_pend = 1'b0;
        pend      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_pend = 1'b0;
            end else begin
                if (have_pend) begin
                    check("load_q", 32'(bus.q), 32'(pend.q));
                    check("load_owner", 32'(bus.owner), 32'(pend.owner));
                    have_pend = 1'b0;
                end
                if (bus.sel == 1'b0 || bus.gnt != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant actual gnt=%b sel=%b required no grant", bus.gnt, bus.sel);
                    end else begin
                        pend = exp_q.pop_front();
                        check("grant", 32'({bus.sel, bus.gnt}), 32'({1'b0, pend.gnt}));
                        have_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int idx;
        bus.req  = '0;
        bus.data = '0;

        // Reset then idle
        tick(2);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle_%0d", i), status(), mk(8'h00, 1'b1, 4'b0000, 1'b0, 2'd0));
        end

        // Single request, dropped once granted
        set_data(2, 8'hA5);
        bus.req = 4'b0100;
        expect_load(2, 8'hA5);
        tick();
        check("single_gnt", 32'(bus.gnt), 32'(4'b0100));
        bus.req = 4'b0000;
        tick();
        check("single_hold1", status(), mk(8'hA5, 1'b1, 4'b0000, 1'b1, 2'd2));
        tick();
        check("single_hold2", status(), mk(8'hA5, 1'b1, 4'b0000, 1'b1, 2'd2));
        tick();
        check("single_idle", status(), mk(8'hA5, 1'b1, 4'b0000, 1'b0, 2'd2));

        // Fairness: all requesting, pointer restarted by reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
        bus.req = 4'b1111;
        for (int s = 0; s < 5; s++) begin
`ifdef LOAD_ARB_FIXED_PRIO_EN
            idx = 0;
`else
            idx = s % N;
`endif
            expect_load(idx, 8'(8'h10 + idx));
        end
        tick(16);
        check("rr_slot_idle", 32'(bus.gnt), 32'(4'b0000));
        tick();
        check("rr_slot_gnt5", 32'(bus.gnt), 32'(4'b0001));
        bus.req = 4'b0000;
        tick(4);

        // Hold stability: q frozen while data/req churn during HOLD
        set_data(0, 8'h3C);
        bus.req = 4'b0001;
        expect_load(0, 8'h3C);
        tick();
        bus.req = 4'b0000;
        tick();
        for (int i = 0; i < N; i++) set_data(i, 8'(8'hE0 + i));
        bus.req = 4'b1010;
        check("hold_q_a", 32'(bus.q), 32'(8'h3C));
        tick();
        bus.req = 4'b0100;
        expect_load(2, 8'hE2);
        check("hold_q_b", 32'(bus.q), 32'(8'h3C));
        tick();
        check("hold_q_c", 32'(bus.q), 32'(8'h3C));
        tick();
        check("hold_q_d", 32'(bus.q), 32'(8'h3C));
        bus.req = 4'b0000;
        tick(4);

        // Winner drops request during GRANT
        set_data(3, 8'h77);
        bus.req = 4'b1000;
        expect_load(3, 8'h77);
        tick();
        bus.req = 4'b0000;
        tick(4);

        // Asynchronous reset in the middle of HOLD
        set_data(2, 8'h5A);
        bus.req = 4'b0100;
        expect_load(2, 8'h5A);
        tick();
        bus.req = 4'b0000;
        tick();
        #6;
        rst = 1'b1;
        #1;
        check("areset_state", status(), mk(8'h00, 1'b1, 4'b0000, 1'b0, 2'd0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_data(1, 8'h99);
        set_data(3, 8'h33);
        bus.req = 4'b1010;
        expect_load(1, 8'h99);
        tick();
        check("areset_first_gnt", 32'(bus.gnt), 32'(4'b0010));
        bus.req = 4'b0000;
        tick(4);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
